// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch buffer sitting between a variable-latency instruction
// memory and the core's fetch/decode boundary. Sequential word fetches are
// issued ahead of the core as long as buffer credits allow. Returned words are
// queued in order together with their PCs. A taken branch/jump flushes the
// queue, restarts fetching at the target and throws away every response that
// was already in flight when the redirect happened.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous, active-high; clears all control state
//   redirect     taken branch/jump from execute; flush and refetch
//   redirect_pc  new fetch address, valid with redirect (bits [1:0] ignored)
//   deq          core consumes the head entry this cycle
//   instr_valid  head entry present
//   instr        head instruction word (0 when empty)
//   instr_pc     PC of the head instruction (0 when empty)
//   mem_req      fetch request valid
//   mem_addr     fetch word address, 4-byte aligned
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   response valid (in request order, >=1 cycle after grant)
//   mem_rdata    response instruction word
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int              CNT_W      = $clog2(DEPTH + 1);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_V    = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]     RESET_PC_A = RESET_PC & ~32'd3;

    // FETCH: responses are kept. DRAIN: responses belong to a flushed path.
    typedef enum logic {
        MODE_FETCH = 1'b0,
        MODE_DRAIN = 1'b1
    } mode_e;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Entry storage carries no reset: count gates every read of it.
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];

    mode_e            mode;
    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] outstanding_nxt;

    // ------------------------------------------------------------------
    // Combinational request / response decisions
    // ------------------------------------------------------------------
    always_comb begin
        mode      = (drop != '0) ? MODE_DRAIN : MODE_FETCH;

        // Every buffered entry and every fetch in flight holds one slot, so
        // a response can never find the queue full.
        credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_V;

        mem_req   = !reset && !redirect && credit_ok;
        issue     = mem_req && mem_gnt;

        // A response arriving together with a redirect is stale by definition.
        push      = mem_rvalid && !redirect && (mode == MODE_FETCH);
        pop       = deq && !redirect && (count != '0);

        // Redirect blocks issue, so in that cycle this is just the in-flight
        // total minus whatever returns right now.
        outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(mem_rvalid);
    end

    // ------------------------------------------------------------------
    // Control state update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC_A;
            resp_pc     <= RESET_PC_A;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'd3;
                resp_pc  <= redirect_pc & ~32'd3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Everything still in flight after this cycle is stale; a
                // second redirect during DRAIN simply recounts from the total.
                drop     <= outstanding_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (mem_rvalid && (mode == MODE_DRAIN)) begin
                    drop <= drop - CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    // ------------------------------------------------------------------
    // Head-of-queue outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_valid = (count != '0);
        instr       = instr_valid ? instr_mem[rd_ptr] : 32'd0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr]    : 32'd0;
        mem_addr    = fetch_pc;
    end

    // A response with nothing in flight means the memory broke the protocol.
    a_no_orphan_resp : assert property (
        @(posedge clk) disable iff (reset)
        !(mem_rvalid && (outstanding == '0))
    );

    a_credit_bound : assert property (
        @(posedge clk) disable iff (reset)
        ({1'b0, count} + {1'b0, outstanding}) <= DEPTH_V
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .deq        (deq),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        dq;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [13];

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } pend_t;
    pend_t       pend [$];
    int          lat_min = 1;
    int          lat_max = 1;
    int          gnt_pct = 100;
    logic [31:0] key     = 32'h0;
    int          cyc     = 0;
    int          dut_grants = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t        mq [$];
    int          m_out;
    int          m_drop;
    logic [31:0] m_fetch;
    logic [31:0] m_resp;

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_out   = 0;
        m_drop  = 0;
        m_fetch = 32'h0;
        m_resp  = 32'h0;
        cyc     = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; deq = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr,                32'd0);
        chk({tag, "_pc"},    instr_pc,             32'd0);
        chk({tag, "_req"},   {31'd0, mem_req},     32'd0);
        chk({tag, "_addr"},  mem_addr,             32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle driven against the memory model, checked against the
    // reference model. Called just after a falling edge, returns at the next.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit dq);
        bit          g;
        bit          rv;
        bit          e_req;
        logic [31:0] rd;
        logic [31:0] old_fetch;
        g  = ($urandom_range(0, 99) < gnt_pct);
        rv = (pend.size() > 0) && (pend[0].rdy <= cyc);
        rd = rv ? (pend[0].addr ^ key) : $urandom;

        redirect = redir; redirect_pc = rpc; deq = dq;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        #1;

        e_req = !redir && ((mq.size() + m_out) < DEPTH);
        chk($sformatf("c%0d_vld", cyc),   {31'd0, instr_valid}, {31'd0, mq.size() != 0});
        chk($sformatf("c%0d_instr", cyc), instr,    (mq.size() != 0) ? mq[0].instr : 32'd0);
        chk($sformatf("c%0d_pc", cyc),    instr_pc, (mq.size() != 0) ? mq[0].pc    : 32'd0);
        chk($sformatf("c%0d_req", cyc),   {31'd0, mem_req}, {31'd0, e_req});
        chk($sformatf("c%0d_addr", cyc),  mem_addr, m_fetch);
        if (mem_req && g) dut_grants++;

        old_fetch = m_fetch;
        if (redir) begin
            mq.delete();
            if (rv) m_out--;
            m_drop  = m_out;
            m_fetch = rpc & ~32'd3;
            m_resp  = rpc & ~32'd3;
        end else begin
            if (dq && mq.size() > 0) void'(mq.pop_front());
            if (rv) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else begin
                    mq.push_back('{rd, m_resp});
                    m_resp = m_resp + 32'd4;
                end
            end
            if (e_req && g) begin
                m_out++;
                m_fetch = m_fetch + 32'd4;
                pend.push_back('{old_fetch, cyc + $urandom_range(lat_min, lat_max)});
            end
        end
        if (rv) void'(pend.pop_front());

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        // redir rpc dq gnt rv rdata | vld instr pc req addr
        tbl[0]  = '{0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h0};
        tbl[1]  = '{0, 32'h0,   0, 1, 1, 32'h1111_0000, 0, 32'h0,         32'h0,   1, 32'h4};
        tbl[2]  = '{0, 32'h0,   0, 0, 1, 32'h2222_0004, 1, 32'h1111_0000, 32'h0,   1, 32'h8};
        tbl[3]  = '{0, 32'h0,   1, 1, 0, 32'h0,         1, 32'h1111_0000, 32'h0,   1, 32'h8};
        tbl[4]  = '{0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h2222_0004, 32'h4,   1, 32'hC};
        tbl[5]  = '{0, 32'h0,   0, 1, 1, 32'h3333_0008, 1, 32'h2222_0004, 32'h4,   1, 32'h10};
        tbl[6]  = '{0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h2222_0004, 32'h4,   0, 32'h14};
        tbl[7]  = '{1, 32'h103, 1, 1, 1, 32'h4444_000C, 1, 32'h2222_0004, 32'h4,   0, 32'h14};
        tbl[8]  = '{0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h100};
        tbl[9]  = '{0, 32'h0,   0, 0, 1, 32'hDEAD_DEAD, 0, 32'h0,         32'h0,   1, 32'h104};
        tbl[10] = '{0, 32'h0,   0, 0, 1, 32'h5555_0100, 0, 32'h0,         32'h0,   1, 32'h104};
        tbl[11] = '{0, 32'h0,   1, 0, 0, 32'h0,         1, 32'h5555_0100, 32'h100, 1, 32'h104};
        tbl[12] = '{0, 32'h0,   1, 0, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h104};

        do_reset("rst0");
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; deq = tbl[i].dq;
            mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_vld", i),   {31'd0, instr_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_instr", i), instr,    tbl[i].e_instr);
            chk($sformatf("tbl%0d_pc", i),    instr_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_req", i),   {31'd0, mem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  mem_addr, tbl[i].e_addr);
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming, 1-cycle memory, word == address.
        do_reset("rst1");
        lat_min = 1; lat_max = 1; gnt_pct = 100; key = 32'h0;
        for (int i = 0; i < 20; i++) cycle(0, 32'h0, 1);

        // Back-pressure: exactly DEPTH grants, then one more after a pop.
        do_reset("rst2");
        dut_grants = 0;
        for (int i = 0; i < 8; i++) cycle(0, 32'h0, 0);
        chk("full_grants", dut_grants, 32'd4);
        cycle(0, 32'h0, 1);
        chk("refill_req",  {31'd0, mem_req}, 32'd1);
        chk("refill_addr", mem_addr, 32'h10);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0);

        // Redirect with three fetches in flight on a slow memory.
        do_reset("rst3");
        lat_min = 4; lat_max = 4; key = 32'hA5A5_0000;
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0);
        cycle(1, 32'h40, 0);
        for (int i = 0; i < 14; i++) cycle(0, 32'h0, 0);

        // Address wrap past the top of the address space.
        do_reset("rst4");
        lat_min = 1; lat_max = 1;
        cycle(1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 10; i++) cycle(0, 32'h0, 1);

        // Asynchronous reset with a full queue.
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 0);
        chk("pre_rst_vld", {31'd0, instr_valid}, 32'd1);
        #2;
        do_reset("async");
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1);

        // Randomised traffic.
        lat_min = 1; lat_max = 4; gnt_pct = 70; key = 32'h5A5A_0F0F;
        for (int i = 0; i < 2000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) < 3);
            cycle(r, $urandom, ($urandom_range(0, 99) < 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
